// File: rtl/seq_multiplier.sv
// Iterative shift-and-add multiplier: one partial product per cycle, signed or unsigned,
// with start/busy/done handshake and optional early exit once the multiplier runs out of ones.
module seq_multiplier #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_TERM = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t               state;
  state_t               state_next;
  logic [WIDTH-1:0]     a_reg;
  logic [2*WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        count;
  logic                 neg;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic                 stop_early;

  // The most negative signed value negates to itself, which read unsigned is its magnitude.
  always_comb begin
    a_mag      = (signed_mode && a[WIDTH-1]) ? -a : a;
    b_mag      = (signed_mode && b[WIDTH-1]) ? -b : b;
    stop_early = EARLY_TERM && (a_reg == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (start) state_next = CALC;
      CALC:   if (stop_early || count == LAST_COUNT) state_next = FINISH;
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath: capture magnitudes, accumulate shifted multiplicand, apply sign at the end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      count   <= '0;
      neg     <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a_mag;
            b_reg <= {{WIDTH{1'b0}}, b_mag};
            acc   <= '0;
            count <= '0;
            neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          end
        end
        CALC: begin
          if (!stop_early) begin
            if (a_reg[0]) acc <= acc + b_reg;
            a_reg <= a_reg >> 1;
            b_reg <= b_reg << 1;
            count <= count + CW'(1);
          end
        end
        FINISH: begin
          product <= neg ? -acc : acc;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: fixed-latency and early-exit 8-bit instances plus a 32-bit instance.
module tb_seq_multiplier;

  logic        clk;
  logic        rst_n;
  logic [2:0]  start_v;
  logic [2:0]  sm_v;
  logic [31:0] a_v [3];
  logic [31:0] b_v [3];
  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  logic [15:0] p0;
  logic [15:0] p1;
  logic [63:0] p2;
  logic [63:0] last_prod [3];
  int          vectors;
  int          miscompares;

  seq_multiplier #(.WIDTH(8), .EARLY_TERM(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .signed_mode(sm_v[0]),
    .a(a_v[0][7:0]), .b(b_v[0][7:0]), .busy(busy_v[0]), .done(done_v[0]), .product(p0)
  );

  seq_multiplier #(.WIDTH(8), .EARLY_TERM(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .signed_mode(sm_v[1]),
    .a(a_v[1][7:0]), .b(b_v[1][7:0]), .busy(busy_v[1]), .done(done_v[1]), .product(p1)
  );

  seq_multiplier #(.WIDTH(32), .EARLY_TERM(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .signed_mode(sm_v[2]),
    .a(a_v[2]), .b(b_v[2]), .busy(busy_v[2]), .done(done_v[2]), .product(p2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] prod_of(input int sel);
    case (sel)
      0:       return {48'b0, p0};
      1:       return {48'b0, p1};
      default: return p2;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive a request, let edge 0 take it, then scramble operands to show they are no longer used.
  task automatic applyStimulus(input int sel, input bit sm, input logic [31:0] aa, input logic [31:0] bb);
    start_v[sel] = 1'b1;
    sm_v[sel]    = sm;
    a_v[sel]     = aa;
    b_v[sel]     = bb;
    @(posedge clk); #1;
    start_v[sel] = 1'b0;
    sm_v[sel]    = ~sm;
    a_v[sel]     = ~aa;
    b_v[sel]     = ~bb;
  endtask

  task automatic run_vec(input int sel, input bit sm, input logic [31:0] aa, input logic [31:0] bb,
                         input logic [63:0] exp_prod, input int exp_lat, input bit inject,
                         input bit at_done, input string tag);
    int lat;
    int busy_cnt;
    if (!at_done) @(negedge clk);
    applyStimulus(sel, sm, aa, bb);
    checkOutput({tag, "/hold"}, prod_of(sel), last_prod[sel]);
    lat      = 0;
    busy_cnt = busy_v[sel] ? 1 : 0;
    while (!done_v[sel] && lat < 80) begin
      @(posedge clk); #1;
      lat++;
      if (busy_v[sel]) busy_cnt++;
      if (inject && lat == 3) begin
        start_v[sel] = 1'b1;
        sm_v[sel]    = 1'b1;
        a_v[sel]     = 32'd3;
        b_v[sel]     = 32'd3;
      end else if (inject && lat == 4) begin
        start_v[sel] = 1'b0;
      end
    end
    start_v[sel] = 1'b0;
    checkOutput({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({tag, "/product"}, prod_of(sel), exp_prod);
    checkOutput({tag, "/busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
    checkOutput({tag, "/busy_with_done"}, {63'b0, busy_v[sel]}, 64'd0);
    last_prod[sel] = exp_prod;
  endtask

  initial begin
    int done_seen;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    start_v     = '0;
    sm_v        = '0;
    for (int i = 0; i < 3; i++) begin
      a_v[i]       = '0;
      b_v[i]       = '0;
      last_prod[i] = '0;
    end
    #1;
    checkOutput("reset/busy", {61'b0, busy_v}, 64'd0);
    checkOutput("reset/done", {61'b0, done_v}, 64'd0);
    checkOutput("reset/product0", prod_of(0), 64'd0);
    checkOutput("reset/product2", prod_of(2), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fixed latency, 8 bit
    run_vec(0, 1'b0, 32'hFF, 32'hFF, 64'hFE01, 9, 1'b0, 1'b0, "u_ff_ff");
    @(posedge clk); #1;
    checkOutput("done_one_cycle", {63'b0, done_v[0]}, 64'd0);
    run_vec(0, 1'b1, 32'h80, 32'hFF, 64'h0080, 9, 1'b0, 1'b0, "s_m128_m1");
    run_vec(0, 1'b1, 32'hFD, 32'h07, 64'hFFEB, 9, 1'b0, 1'b0, "s_m3_7");
    run_vec(0, 1'b1, 32'h80, 32'h80, 64'h4000, 9, 1'b0, 1'b0, "s_80_80");
    run_vec(0, 1'b0, 32'h80, 32'h80, 64'h4000, 9, 1'b0, 1'b0, "u_80_80");

    // Handshake: ignored mid-op start, then a start issued in the done cycle
    run_vec(0, 1'b0, 32'hFF, 32'hFF, 64'hFE01, 9, 1'b1, 1'b0, "mid_start");
    run_vec(0, 1'b1, 32'hFD, 32'h07, 64'hFFEB, 9, 1'b0, 1'b1, "done_cycle_start");

    // Early termination, 8 bit
    run_vec(1, 1'b0, 32'h03, 32'h05, 64'd15, 4, 1'b0, 1'b0, "et_3_5");
    run_vec(1, 1'b0, 32'h00, 32'hAA, 64'd0, 2, 1'b0, 1'b0, "et_0_aa");
    run_vec(1, 1'b0, 32'h80, 32'h03, 64'h0180, 9, 1'b0, 1'b0, "et_80_3");
    run_vec(1, 1'b1, 32'hFD, 32'h07, 64'hFFEB, 4, 1'b0, 1'b0, "et_s_m3_7");
    run_vec(1, 1'b1, 32'h80, 32'hFF, 64'h0080, 9, 1'b0, 1'b0, "et_s_m128_m1");

    // 32 bit
    run_vec(2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33, 1'b0, 1'b0, "w32_u_max");
    run_vec(2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 33, 1'b0, 1'b0, "w32_s_m1_m1");
    run_vec(2, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000, 33, 1'b0, 1'b0, "w32_s_min_max");
    run_vec(2, 1'b0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 33, 1'b0, 1'b0, "w32_u_pow");

    // Asynchronous reset in cycle 4 of 9
    @(negedge clk);
    applyStimulus(0, 1'b0, 32'hFF, 32'hFF);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset/busy", {63'b0, busy_v[0]}, 64'd0);
    checkOutput("midreset/done", {63'b0, done_v[0]}, 64'd0);
    checkOutput("midreset/product", prod_of(0), 64'd0);
    for (int i = 0; i < 3; i++) last_prod[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done_v[0]) done_seen++;
    end
    checkOutput("midreset/no_done", 64'(done_seen), 64'd0);
    run_vec(0, 1'b1, 32'h80, 32'hFF, 64'h0080, 9, 1'b0, 1'b0, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
